bsg_fifo_scoreboard: RTL

Synthesizable, parametrised FIFO checker that shadows any ready/valid FIFO of depth `els_p` and width `width_p` (bsg_two_fifo is the `els_p=2` case). It observes the enqueue and dequeue handshakes, keeps a reference model with its own occupancy count and data queue, and reports sticky error bits, first-error code and cycle, and transfer counters. It sits beside the FIFO under test in formal and simulation harnesses, and can also be instantiated in silicon debug builds.

---
 rtl/bsg_fifo_scoreboard.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bsg_fifo_scoreboard.sv
// Reference-model checker for a ready/valid FIFO: shadows occupancy and data,
// and reports sticky per-check error bits, first-error code/cycle and transfer counts.
module bsg_fifo_scoreboard #(
    parameter int width_p       = 8,
    parameter int els_p         = 2,
    parameter int check_flags_p = 1,
    parameter int ctr_width_p   = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enq_v_i,
    input  logic                         enq_ready_i,
    input  logic [width_p-1:0]           enq_data_i,
    input  logic                         deq_v_i,
    input  logic                         deq_yumi_i,
    input  logic [width_p-1:0]           deq_data_i,
    input  logic                         full_i,
    input  logic                         empty_i,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic [6:0]                   err_o,
    output logic                         err_any_o,
    output logic [2:0]                   first_err_o,
    output logic [ctr_width_p-1:0]       first_err_cycle_o,
    output logic [ctr_width_p-1:0]       enq_cnt_o,
    output logic [ctr_width_p-1:0]       deq_cnt_o
);

    localparam int cnt_width_lp = $clog2(els_p+1);
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(els_p);
    localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p-1);
    localparam logic [ctr_width_p-1:0]  ctr_one_lp  = ctr_width_p'(1);

    logic [width_p-1:0]      mem_reg [els_p];
    logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
    logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
    logic [cnt_width_lp-1:0] cnt_reg, cnt_next;
    logic [6:0]              err_reg, err_now, err_next;
    logic [2:0]              first_err_reg, first_code;
    logic [ctr_width_p-1:0]  first_err_cycle_reg;
    logic [ctr_width_p-1:0]  cycle_reg, enq_cnt_reg, deq_cnt_reg;

    logic enque, deque, model_full, model_empty, legal_enq, legal_deq;
    logic flags_en;

    assign enque       = enq_v_i & enq_ready_i;
    assign deque       = deq_yumi_i;
    assign model_full  = (cnt_reg == cnt_full_lp);
    assign model_empty = (cnt_reg == '0);
    assign legal_enq   = enque & ~model_full & ~reset_i;
    assign legal_deq   = deque & ~model_empty & ~reset_i;
    assign flags_en    = (check_flags_p != 0);

    // The shadow head is read combinationally so it can be compared in the same cycle as the pop.
    always_comb begin
        err_now    = '0;
        err_now[0] = enque & model_full;
        err_now[1] = deque & model_empty;
        err_now[2] = deque & ~model_empty & (deq_data_i != mem_reg[rptr_reg]);
        err_now[3] = flags_en & (full_i != model_full);
        err_now[4] = flags_en & (empty_i != model_empty);
        err_now[5] = (enq_ready_i != ~model_full);
        err_now[6] = (deq_v_i != ~model_empty) | (deq_yumi_i & ~deq_v_i);
        if (reset_i) begin
            err_now = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_sticky
            assign err_next[gi] = err_reg[gi] | err_now[gi];
        end
    endgenerate

    // Descending scan so the lowest-numbered firing check ends up winning.
    always_comb begin
        first_code = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (err_now[i]) begin
                first_code = 3'(i);
            end
        end
    end

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (legal_enq) begin
            wptr_next = (wptr_reg == ptr_last_lp) ? '0 : wptr_reg + 1'b1;
        end
        if (legal_deq) begin
            rptr_next = (rptr_reg == ptr_last_lp) ? '0 : rptr_reg + 1'b1;
        end
        cnt_next = cnt_reg + cnt_width_lp'(legal_enq) - cnt_width_lp'(legal_deq);
    end

    // Data storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (legal_enq) begin
            mem_reg[wptr_reg] <= enq_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_reg            <= '0;
            rptr_reg            <= '0;
            cnt_reg             <= '0;
            err_reg             <= '0;
            first_err_reg       <= 3'd7;
            first_err_cycle_reg <= '0;
            cycle_reg           <= '0;
            enq_cnt_reg         <= '0;
            deq_cnt_reg         <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            cycle_reg <= cycle_reg + ctr_one_lp;
            if (legal_enq) begin
                enq_cnt_reg <= enq_cnt_reg + ctr_one_lp;
            end
            if (legal_deq) begin
                deq_cnt_reg <= deq_cnt_reg + ctr_one_lp;
            end
            if ((|err_now) && !(|err_reg)) begin
                first_err_reg       <= first_code;
                first_err_cycle_reg <= cycle_reg;
            end
        end
    end

    assign count_o           = cnt_reg;
    assign err_o             = err_reg;
    assign err_any_o         = |err_reg;
    assign first_err_o       = first_err_reg;
    assign first_err_cycle_o = first_err_cycle_reg;
    assign enq_cnt_o         = enq_cnt_reg;
    assign deq_cnt_o         = deq_cnt_reg;

endmodule
